// File: rtl/memory_arbiter.sv
// memory_arbiter: two-port (fetch/data) arbiter in front of a single-port,
// one-cycle-latency synchronous memory. Data has priority over fetch, but a
// streak counter forces a fetch grant after two data grants made while a
// fetch was waiting. Every output is a register.
module memory_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetchReq,
  input  logic [ADDR_WIDTH-1:0] fetchAddr,
  output logic                  fetchGrant,
  output logic                  fetchValid,
  output logic [DATA_WIDTH-1:0] fetchData,
  input  logic                  dataReq,
  input  logic                  dataWrite,
  input  logic [ADDR_WIDTH-1:0] dataAddr,
  input  logic [DATA_WIDTH-1:0] dataWriteData,
  output logic                  dataGrant,
  output logic                  dataValid,
  output logic [DATA_WIDTH-1:0] dataReadData,
  output logic                  memEnable,
  output logic                  memWriteEnable,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0] memWriteData,
  input  logic [DATA_WIDTH-1:0] memReadData
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state, state_d;
  logic [1:0]            streak, streak_d;
  logic                  serve_fetch, serve_fetch_d;
  logic                  serve_write, serve_write_d;
  logic                  arb_go, pick_fetch;
  logic                  fetch_grant_d, data_grant_d;
  logic                  fetch_valid_d, data_valid_d;
  logic                  mem_en_d, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;
  logic [DATA_WIDTH-1:0] fetch_data_d, data_rd_d;

  // Next-state logic: arbitrate in IDLE or RESP, ACCESS always lasts one cycle.
  always_comb begin
    arb_go     = ((state == IDLE) || (state == RESP)) && (fetchReq || dataReq);
    pick_fetch = fetchReq && (!dataReq || (streak == 2'd2));
    state_d    = IDLE;
    unique case (state)
      IDLE, RESP: state_d = arb_go ? ACCESS : IDLE;
      ACCESS:     state_d = RESP;
      default:    state_d = IDLE;
    endcase
  end

  // Output logic: next values of every registered output and bookkeeping reg.
  always_comb begin
    fetch_grant_d = arb_go && pick_fetch;
    data_grant_d  = arb_go && !pick_fetch;
    mem_en_d      = arb_go;
    mem_we_d      = arb_go && !pick_fetch && dataWrite;
    mem_addr_d    = memAddress;
    mem_wdata_d   = memWriteData;
    serve_fetch_d = serve_fetch;
    serve_write_d = serve_write;
    streak_d      = streak;
    if (arb_go) begin
      serve_fetch_d = pick_fetch;
      serve_write_d = !pick_fetch && dataWrite;
      if (pick_fetch) begin
        mem_addr_d = fetchAddr;
        streak_d   = '0;
      end else begin
        mem_addr_d  = dataAddr;
        mem_wdata_d = dataWriteData;
        if (fetchReq && (streak != 2'd2))
          streak_d = streak + 2'd1;
      end
    end
    // Memory read data is valid during RESP; capture it on the RESP-exit edge.
    fetch_valid_d = (state == RESP) && serve_fetch;
    data_valid_d  = (state == RESP) && !serve_fetch;
    fetch_data_d  = fetch_valid_d ? memReadData : fetchData;
    data_rd_d     = (data_valid_d && !serve_write) ? memReadData : dataReadData;
  end

  // State and output registers, all cleared by the asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      streak         <= '0;
      serve_fetch    <= 1'b0;
      serve_write    <= 1'b0;
      fetchGrant     <= 1'b0;
      dataGrant      <= 1'b0;
      fetchValid     <= 1'b0;
      dataValid      <= 1'b0;
      memEnable      <= 1'b0;
      memWriteEnable <= 1'b0;
      memAddress     <= '0;
      memWriteData   <= '0;
      fetchData      <= '0;
      dataReadData   <= '0;
    end else begin
      state          <= state_d;
      streak         <= streak_d;
      serve_fetch    <= serve_fetch_d;
      serve_write    <= serve_write_d;
      fetchGrant     <= fetch_grant_d;
      dataGrant      <= data_grant_d;
      fetchValid     <= fetch_valid_d;
      dataValid      <= data_valid_d;
      memEnable      <= mem_en_d;
      memWriteEnable <= mem_we_d;
      memAddress     <= mem_addr_d;
      memWriteData   <= mem_wdata_d;
      fetchData      <= fetch_data_d;
      dataReadData   <= data_rd_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a small synchronous memory model.
module tb_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fetchReq = 1'b0;
  logic [15:0] fetchAddr = '0;
  logic        fetchGrant, fetchValid;
  logic [15:0] fetchData;
  logic        dataReq = 1'b0;
  logic        dataWrite = 1'b0;
  logic [15:0] dataAddr = '0;
  logic [15:0] dataWriteData = '0;
  logic        dataGrant, dataValid;
  logic [15:0] dataReadData;
  logic        memEnable, memWriteEnable;
  logic [15:0] memAddress, memWriteData;
  logic [15:0] memReadData = '0;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mem [0:255];

  memory_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clock(clock), .reset(reset),
    .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchGrant(fetchGrant),
    .fetchValid(fetchValid), .fetchData(fetchData),
    .dataReq(dataReq), .dataWrite(dataWrite), .dataAddr(dataAddr),
    .dataWriteData(dataWriteData), .dataGrant(dataGrant), .dataValid(dataValid),
    .dataReadData(dataReadData),
    .memEnable(memEnable), .memWriteEnable(memWriteEnable),
    .memAddress(memAddress), .memWriteData(memWriteData),
    .memReadData(memReadData)
  );

  always #5 clock = ~clock;

  // Memory model: one-cycle read latency, write on enabled edge.
  always @(posedge clock) begin
    if (memEnable) begin
      if (memWriteEnable) mem[memAddress[7:0]] <= memWriteData;
      else                memReadData <= mem[memAddress[7:0]];
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    fetchReq = 1'b0;
    dataReq = 1'b0;
    dataWrite = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({fetchGrant, fetchValid, dataGrant, dataValid, memEnable, memWriteEnable} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl got=%b want=000000",
               {fetchGrant, fetchValid, dataGrant, dataValid, memEnable, memWriteEnable});
    end
    n_cmp++;
    if ({memAddress, memWriteData, fetchData, dataReadData} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_data got=%h want=0", {memAddress, memWriteData, fetchData, dataReadData});
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_store_then_fetch();
    dataReq = 1'b1; dataWrite = 1'b1; dataAddr = 16'h0005; dataWriteData = 16'hFA2D;
    step();
    n_cmp++;
    if ({dataGrant, fetchGrant, memEnable, memWriteEnable, memAddress, memWriteData} !== {4'b1011, 16'h0005, 16'hFA2D}) begin
      n_err++;
      $display("FAIL store_grant got=%b %h %h want=1011 0005 fa2d",
               {dataGrant, fetchGrant, memEnable, memWriteEnable}, memAddress, memWriteData);
    end
    dataReq = 1'b0; dataWrite = 1'b0;
    step();
    n_cmp++;
    if ({dataGrant, dataValid, memEnable, memWriteEnable} !== 4'b0000) begin
      n_err++;
      $display("FAIL store_resp got=%b want=0000", {dataGrant, dataValid, memEnable, memWriteEnable});
    end
    step();
    n_cmp++;
    if ({dataValid, fetchValid, dataReadData} !== {2'b10, 16'h0000}) begin
      n_err++;
      $display("FAIL store_valid got=%b %h want=10 0000", {dataValid, fetchValid}, dataReadData);
    end
    fetchReq = 1'b1; fetchAddr = 16'h0005;
    step();
    n_cmp++;
    if ({fetchGrant, dataGrant, dataValid, memWriteEnable, memAddress} !== {4'b1000, 16'h0005}) begin
      n_err++;
      $display("FAIL fetch_grant got=%b %h want=1000 0005",
               {fetchGrant, dataGrant, dataValid, memWriteEnable}, memAddress);
    end
    fetchReq = 1'b0;
    step();
    step();
    n_cmp++;
    if ({fetchValid, fetchData} !== {1'b1, 16'hFA2D}) begin
      n_err++;
      $display("FAIL fetch_readback got=%b %h want=1 fa2d", fetchValid, fetchData);
    end
    step();
    n_cmp++;
    if (fetchValid !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_pulse_width got=%b want=0", fetchValid);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    fetchReq = 1'b1; fetchAddr = 16'h0001;
    dataReq = 1'b1; dataWrite = 1'b0; dataAddr = 16'h0003;
    step();
    n_cmp++;
    if ({dataGrant, fetchGrant, memAddress} !== {2'b10, 16'h0003}) begin
      n_err++;
      $display("FAIL simul_first got=%b %h want=10 0003", {dataGrant, fetchGrant}, memAddress);
    end
    dataReq = 1'b0;
    step();
    n_cmp++;
    if ({dataGrant, fetchGrant} !== 2'b00) begin
      n_err++;
      $display("FAIL simul_gap got=%b want=00", {dataGrant, fetchGrant});
    end
    step();
    n_cmp++;
    if ({dataValid, dataReadData, fetchGrant, fetchValid, memAddress} !== {1'b1, 16'hDEF0, 2'b10, 16'h0001}) begin
      n_err++;
      $display("FAIL simul_second got=%b %h %b %h want=1 def0 10 0001",
               dataValid, dataReadData, {fetchGrant, fetchValid}, memAddress);
    end
    fetchReq = 1'b0;
    step();
    step();
    n_cmp++;
    if ({fetchValid, fetchData, dataValid} !== {1'b1, 16'h5678, 1'b0}) begin
      n_err++;
      $display("FAIL simul_fetch_valid got=%b %h %b want=1 5678 0", fetchValid, fetchData, dataValid);
    end
  endtask

  task automatic test_starvation();
    logic [5:0] want_fetch;
    want_fetch = 6'b100100;  // bit k: grant k (0 first) goes to fetch
    apply_reset();
    fetchReq = 1'b1; fetchAddr = 16'h0002;
    dataReq = 1'b1; dataWrite = 1'b0; dataAddr = 16'h0010;
    for (int k = 0; k < 6; k++) begin
      step();
      n_cmp++;
      if ({fetchGrant, dataGrant} !== {want_fetch[k], ~want_fetch[k]}) begin
        n_err++;
        $display("FAIL starve_grant%0d got=%b want=%b", k, {fetchGrant, dataGrant},
                 {want_fetch[k], ~want_fetch[k]});
      end
      if (dataGrant) dataAddr = dataAddr + 16'h0001;
      step();
    end
    fetchReq = 1'b0; dataReq = 1'b0;
    step();
    step();
  endtask

  task automatic test_idle_hold();
    logic ok;
    apply_reset();
    fetchReq = 1'b1; fetchAddr = 16'h0001;
    step();
    fetchReq = 1'b0;
    step();
    step();
    n_cmp++;
    if ({fetchValid, fetchData} !== {1'b1, 16'h5678}) begin
      n_err++;
      $display("FAIL idle_fetch got=%b %h want=1 5678", fetchValid, fetchData);
    end
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if ({fetchValid, dataValid, memEnable, fetchGrant, dataGrant, fetchData} !== {5'b0, 16'h5678}) ok = 1'b0;
    end
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL idle_hold got=%b %h want=00000 5678",
               {fetchValid, dataValid, memEnable, fetchGrant, dataGrant}, fetchData);
    end
  endtask

  task automatic test_mid_access_reset();
    logic seen_valid;
    apply_reset();
    dataReq = 1'b1; dataWrite = 1'b0; dataAddr = 16'h0003;
    step();
    dataReq = 1'b0;
    step();
    step();
    n_cmp++;
    if ({dataValid, dataReadData} !== {1'b1, 16'hDEF0}) begin
      n_err++;
      $display("FAIL mar_preload got=%b %h want=1 def0", dataValid, dataReadData);
    end
    dataReq = 1'b1; dataAddr = 16'h0002;
    step();
    n_cmp++;
    if ({dataGrant, memEnable} !== 2'b11) begin
      n_err++;
      $display("FAIL mar_access got=%b want=11", {dataGrant, memEnable});
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({dataGrant, dataValid, memEnable, memAddress, dataReadData} !== 35'h0) begin
      n_err++;
      $display("FAIL mar_async_clear got=%b %h %h want=000 0000 0000",
               {dataGrant, dataValid, memEnable}, memAddress, dataReadData);
    end
    dataReq = 1'b0;
    step();
    reset = 1'b0;
    seen_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (dataValid !== 1'b0) seen_valid = 1'b1;
    end
    n_cmp++;
    if (seen_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mar_no_valid got=%b want=0", seen_valid);
    end
    dataReq = 1'b1; dataAddr = 16'h0001;
    step();
    dataReq = 1'b0;
    n_cmp++;
    if (dataGrant !== 1'b1) begin
      n_err++;
      $display("FAIL mar_regrant got=%b want=1", dataGrant);
    end
    step();
    step();
    n_cmp++;
    if ({dataValid, dataReadData} !== {1'b1, 16'h5678}) begin
      n_err++;
      $display("FAIL mar_after got=%b %h want=1 5678", dataValid, dataReadData);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    dataReq = 1'b1; dataWrite = 1'b0; dataAddr = 16'h0000;
    step();
    dataAddr = 16'h0001;
    step();
    n_cmp++;
    if (dataValid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_gap0 got=%b want=0", dataValid);
    end
    step();
    n_cmp++;
    if ({dataGrant, dataValid, dataReadData, memAddress} !== {2'b11, 16'h1234, 16'h0001}) begin
      n_err++;
      $display("FAIL b2b_0 got=%b %h %h want=11 1234 0001", {dataGrant, dataValid}, dataReadData, memAddress);
    end
    dataAddr = 16'h0002;
    step();
    n_cmp++;
    if ({dataValid, dataReadData} !== {1'b0, 16'h1234}) begin
      n_err++;
      $display("FAIL b2b_gap1 got=%b %h want=0 1234", dataValid, dataReadData);
    end
    step();
    n_cmp++;
    if ({dataGrant, dataValid, dataReadData} !== {2'b11, 16'h5678}) begin
      n_err++;
      $display("FAIL b2b_1 got=%b %h want=11 5678", {dataGrant, dataValid}, dataReadData);
    end
    dataReq = 1'b0;
    step();
    step();
    n_cmp++;
    if ({dataGrant, dataValid, dataReadData} !== {2'b01, 16'h9ABC}) begin
      n_err++;
      $display("FAIL b2b_2 got=%b %h want=01 9abc", {dataGrant, dataValid}, dataReadData);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1234;
    mem[1] = 16'h5678;
    mem[2] = 16'h9ABC;
    mem[3] = 16'hDEF0;
    test_reset();
    test_store_then_fetch();
    test_simultaneous();
    test_starvation();
    test_idle_hold();
    test_mid_access_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
